string_receiver: RTL and testbench
==================================

STRING_RECEIVER -- requirements
Module: string_receiver

Interface
REQ-001 Parameter RX_STRING_COUNT_BIT, default 4, width of the length counter and length output.
REQ-002 Parameter RX_STRING_MAX_LENGTH, default 13, maximum payload characters per string; SHALL be at most 2^RX_STRING_COUNT_BIT-3.
REQ-003 Parameter RX_STRING_MAX_BIT_LENGTH, default RX_STRING_MAX_LENGTH*8, string bus width.
REQ-004 Parameter ClkFrequency, default 50000000, board clock in Hz.
REQ-005 Parameter Baud, default 57600, serial bit rate.
REQ-006 clk  input  1  single system clock; all logic on posedge.
REQ-007 reset_n  input  1  synchronous, active-low reset.
REQ-008 RxD  input  1  serial line, 8 data bits, no parity, at least 1 stop bit.
REQ-009 RXStringLen  output  RX_STRING_COUNT_BIT  payload character count of the last completed string.
REQ-010 RXString  output  RX_STRING_MAX_BIT_LENGTH  last completed string, right-aligned.
REQ-011 RXStringReady  output  1  one-cycle strobe: a new string is on RXString/RXStringLen.
REQ-012 RXStringOverflow  output  1  one-cycle strobe: a string exceeded max length and was discarded.

Function
REQ-013 The block SHALL instantiate async_receiver with ClkFrequency and Baud, and SHALL use its RxD_data and RxD_data_ready outputs as the byte stream.
REQ-014 A byte is accepted in each clk cycle where RxD_data_ready=1.
REQ-015 States: EMPTY (no chars buffered), COLLECT (1..MAX chars buffered), DISCARD (overflowed, waiting for terminator).
REQ-016 Terminators: CR (0x0D) and LF (0x0A); terminators are never stored.
REQ-017 EMPTY + terminator -> stay EMPTY, no strobe, so a CR LF pair produces one string.
REQ-018 EMPTY + other byte -> buffer <= byte in low byte, count <= 1, go to COLLECT.
REQ-019 COLLECT + other byte with count<MAX -> buffer <= {buffer shifted left 8, byte}, count+1.
REQ-020 COLLECT + other byte with count==MAX -> clear buffer and count, pulse RXStringOverflow next cycle, go to DISCARD.
REQ-021 COLLECT + terminator -> RXString <= buffer, RXStringLen <= count, pulse RXStringReady in the next cycle (1-cycle latency from the accepting RxD_data_ready), clear buffer and count, go to EMPTY.
REQ-022 DISCARD + terminator -> EMPTY, no strobe. DISCARD + other byte -> remain, no storage.
REQ-023 Output format: first character in the highest occupied byte, last character at bits [7:0], unoccupied upper bytes zero.
REQ-024 RXString and RXStringLen SHALL hold their values until the next completed string and SHALL not change on overflow.
REQ-025 RXStringReady and RXStringOverflow SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per event.
REQ-026 Exactly MAX characters followed by a terminator is valid: RXStringLen=MAX and the full bus is occupied.
REQ-027 Byte 0x00 SHALL be stored as an ordinary character.

Reset
REQ-028 While reset_n=0 at a clk edge: state EMPTY; buffer, count, RXString and RXStringLen zero; both strobes 0.
REQ-029 Reset mid-string SHALL discard the partial string with no strobe.
REQ-030 async_receiver has no reset. A byte completing during reset is ignored; a byte completing after reset release is accepted normally.

Verification
REQ-031 Serial "AB\r\n" -> single RXStringReady pulse; RXStringLen=2; RXString[15:0]=0x4142; upper bits zero; no overflow.
REQ-032 Serial "\r\n\r" only -> no RXStringReady and no RXStringOverflow; outputs stay at their reset values.
REQ-033 "ABCDEFGHIJKLM\r" (13 chars) -> RXStringLen=13, RXString=0x4142...4D; then 14 chars + "\r" -> one RXStringOverflow pulse on the 14th char, no Ready, previous RXString and RXStringLen retained.
REQ-034 After the REQ-033 overflow, "X\r" -> RXStringLen=1; RXString=0x58 (zero-extended); one Ready pulse.
REQ-035 "HEL", reset_n low 2 cycles, then "Q\n" -> only one Ready pulse, with RXStringLen=1 and RXString=0x51.
REQ-036 Back-to-back "A\rB\r" at full baud -> two Ready pulses, carrying 0x41 then 0x42, each with Len=1; Ready is asserted exactly one clk after the terminator's RxD_data_ready.

Source files
------------

// File: rtl/string_receiver.sv
// Purpose : assemble CR/LF-terminated ASCII strings from a UART byte stream.
// Latency : RXStringReady / RXStringOverflow rise 1 clk after the byte that caused them.
// Backpress: none; the serial line cannot be stalled, every received byte is consumed.
//
// Ports (string_receiver):
//   clk              in   system clock, all logic on posedge
//   reset_n          in   synchronous active-low reset
//   RxD              in   serial line, 8N1 (one or more stop bits)
//   RXStringLen      out  payload length of last completed string
//   RXString         out  last completed string, last char at [7:0], unused upper bytes zero
//   RXStringReady    out  1-cycle strobe, new string on RXString/RXStringLen
//   RXStringOverflow out  1-cycle strobe, string longer than max was dropped
//
// Ports (async_receiver):
//   clk in, RxD in, RxD_data_ready out (1-cycle strobe), RxD_data out (byte)

// Purpose : 8N1 UART byte receiver, mid-bit sampling.
// Latency : strobe in the middle of the stop bit.
// Backpress: none; byte is valid only during the strobe cycle.
module async_receiver #(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 57600
) (
  input  logic       clk,
  input  logic       RxD,
  output logic       RxD_data_ready,
  output logic [7:0] RxD_data
);

  localparam int BitClks = ClkFrequency / Baud;
  localparam int CntW    = $clog2(BitClks + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e        state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             rdy_q, rdy_d;
  logic             rx;

  // No reset: every state returns to RX_IDLE within one frame on an idle-high line.
  assign rx = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], RxD};
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rdy_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = RX_START;
      end
      RX_START: begin
        // Re-check the line half a bit in to reject glitches.
        if (cnt_q == CntW'(BitClks / 2 - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CntW'(BitClks - 1)) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};  // LSB first on the wire
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CntW'(BitClks - 1)) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          rdy_d   = rx;  // framing error drops the byte silently
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    sync_q  <= sync_d;
    state_q <= state_d;
    cnt_q   <= cnt_d;
    bit_q   <= bit_d;
    shift_q <= shift_d;
    rdy_q   <= rdy_d;
  end

  assign RxD_data_ready = rdy_q;
  assign RxD_data       = shift_q;

endmodule

// Purpose : collect bytes into a line buffer, publish on CR/LF, drop overlong lines.
// Latency : 1 clk from the terminating byte strobe to RXStringReady.
// Backpress: none; outputs hold until the next completed string.
module string_receiver #(
  parameter int RX_STRING_COUNT_BIT      = 4,
  parameter int RX_STRING_MAX_LENGTH     = 13,
  parameter int RX_STRING_MAX_BIT_LENGTH = RX_STRING_MAX_LENGTH * 8,
  parameter int ClkFrequency             = 50000000,
  parameter int Baud                     = 57600
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                RxD,
  output logic [RX_STRING_COUNT_BIT-1:0]      RXStringLen,
  output logic [RX_STRING_MAX_BIT_LENGTH-1:0] RXString,
  output logic                                RXStringReady,
  output logic                                RXStringOverflow
);

  localparam int CB = RX_STRING_COUNT_BIT;
  localparam int W  = RX_STRING_MAX_BIT_LENGTH;

  typedef enum logic [1:0] {S_EMPTY, S_COLLECT, S_DISCARD} state_e;

  logic       rx_byte_vld;
  logic [7:0] rx_byte_dat;
  logic       is_term;

  state_e          state_q, state_d;
  logic [W-1:0]    buf_q, buf_d;
  logic [CB-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    str_q, str_d;
  logic [CB-1:0]   len_q, len_d;
  logic            rdy_q, rdy_d;
  logic            ovf_q, ovf_d;

  async_receiver #(
    .ClkFrequency (ClkFrequency),
    .Baud         (Baud)
  ) u_rx (
    .clk            (clk),
    .RxD            (RxD),
    .RxD_data_ready (rx_byte_vld),
    .RxD_data       (rx_byte_dat)
  );

  assign is_term = (rx_byte_dat == 8'h0D) || (rx_byte_dat == 8'h0A);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    str_d   = str_q;
    len_d   = len_q;
    rdy_d   = 1'b0;
    ovf_d   = 1'b0;
    if (rx_byte_vld) begin
      case (state_q)
        S_EMPTY: begin
          // A bare terminator (second half of CR LF, blank line) is ignored.
          if (!is_term) begin
            buf_d   = W'(rx_byte_dat);
            cnt_d   = CB'(1);
            state_d = S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (is_term) begin
            str_d   = buf_q;
            len_d   = cnt_q;
            rdy_d   = 1'b1;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = S_EMPTY;
          end else if (cnt_q == CB'(RX_STRING_MAX_LENGTH)) begin
            buf_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b1;
            state_d = S_DISCARD;
          end else begin
            // Shifting left keeps the newest char at [7:0] and the output right-aligned.
            buf_d = (buf_q << 8) | W'(rx_byte_dat);
            cnt_d = cnt_q + CB'(1);
          end
        end
        S_DISCARD: begin
          if (is_term) state_d = S_EMPTY;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
      buf_q   <= '0;
      cnt_q   <= '0;
      str_q   <= '0;
      len_q   <= '0;
      rdy_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      str_q   <= str_d;
      len_q   <= len_d;
      rdy_q   <= rdy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign RXString         = str_q;
  assign RXStringLen      = len_q;
  assign RXStringReady    = rdy_q;
  assign RXStringOverflow = ovf_q;

endmodule

// File: tb/tb_string_receiver.sv
// Purpose : self-checking bench for string_receiver, serial stimulus at 8 clk per bit.
// Latency : checks Ready lands one clk after the terminator byte strobe.
// Backpress: n/a (bench drives the serial line freely).
module tb_string_receiver;

  localparam int BIT = 8;  // 1 MHz / 125 kBd

  logic         clk = 1'b0;
  logic         reset_n;
  logic         RxD;
  logic [3:0]   RXStringLen;
  logic [103:0] RXString;
  logic         RXStringReady;
  logic         RXStringOverflow;

  string_receiver #(
    .RX_STRING_COUNT_BIT      (4),
    .RX_STRING_MAX_LENGTH     (13),
    .RX_STRING_MAX_BIT_LENGTH (104),
    .ClkFrequency             (1000000),
    .Baud                     (125000)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .RxD              (RxD),
    .RXStringLen      (RXStringLen),
    .RXString         (RXString),
    .RXStringReady    (RXStringReady),
    .RXStringOverflow (RXStringOverflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]   len;
    logic [103:0] str;
    int           lat;
  } ev_t;

  ev_t rdy_log[$];
  int  ovf_cnt  = 0;
  int  both_cnt = 0;
  int  cyc      = 0;
  int  last_term_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dut.rx_byte_vld && (dut.rx_byte_dat == 8'h0D || dut.rx_byte_dat == 8'h0A))
      last_term_cyc = cyc;
    if (RXStringReady) begin
      ev_t e;
      e.len = RXStringLen;
      e.str = RXString;
      e.lat = cyc - last_term_cyc;
      rdy_log.push_back(e);
    end
    if (RXStringOverflow) ovf_cnt++;
    if (RXStringReady && RXStringOverflow) both_cnt++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RxD = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (BIT) @(negedge clk);
    end
    RxD = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  // Bytes are packed first-char-highest, n of them right-aligned in dat.
  task automatic send_bytes(input logic [127:0] dat, input int n);
    for (int i = n - 1; i >= 0; i--) send_byte(dat[i*8 +: 8]);
    repeat (20) @(negedge clk);
  endtask

  typedef struct {
    logic [127:0] dat;
    int           n;
    int           exp_rdy;
    int           exp_ovf;
    logic [3:0]   exp_len;
    logic [103:0] exp_str;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [127:0] dat, input int n, input int rdy, input int ovf,
                     input logic [3:0] len, input logic [103:0] str);
    vec_t v;
    v.dat = dat; v.n = n; v.exp_rdy = rdy; v.exp_ovf = ovf; v.exp_len = len; v.exp_str = str;
    vecs.push_back(v);
  endtask

  localparam logic [103:0] ALPHA13 = 104'h4142434445464748494A4B4C4D;

  initial begin
    int r0;
    int o0;
    RxD     = 1'b1;
    reset_n = 1'b0;

    // Bare terminators first, so outputs must still be at reset values afterwards.
    add("\r\n\r",             3,  0, 0, 4'd0,  104'h0);
    add("AB\r\n",             4,  1, 0, 4'd2,  104'h4142);
    add("ABCDEFGHIJKLM\r",    14, 1, 0, 4'd13, ALPHA13);
    add("NOPQRSTUVWXYZ[\r",   15, 0, 1, 4'd13, ALPHA13);
    add("X\r",                2,  1, 0, 4'd1,  104'h58);
    add(128'h4100420D,        4,  1, 0, 4'd3,  104'h410042);
    add("\n\nZZ\r\n",         6,  1, 0, 4'd2,  104'h5A5A);

    repeat (200) @(negedge clk);
    check("reset str",   128'(RXString), 128'h0);
    check("reset len",   128'(RXStringLen), 128'h0);
    check("reset ready", 128'(RXStringReady), 128'h0);
    check("reset ovf",   128'(RXStringOverflow), 128'h0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    rdy_log.delete();
    ovf_cnt  = 0;
    both_cnt = 0;

    foreach (vecs[k]) begin
      r0 = rdy_log.size();
      o0 = ovf_cnt;
      send_bytes(vecs[k].dat, vecs[k].n);
      check($sformatf("v%0d ready pulses", k), 128'(rdy_log.size() - r0), 128'(vecs[k].exp_rdy));
      check($sformatf("v%0d ovf pulses", k),   128'(ovf_cnt - o0),         128'(vecs[k].exp_ovf));
      check($sformatf("v%0d len", k),          128'(RXStringLen),          128'(vecs[k].exp_len));
      check($sformatf("v%0d str", k),          128'(RXString),             128'(vecs[k].exp_str));
    end

    // Reset in the middle of a string drops it without any strobe.
    r0 = rdy_log.size();
    o0 = ovf_cnt;
    send_bytes("HEL", 3);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset str", 128'(RXString), 128'h0);
    check("midreset len", 128'(RXStringLen), 128'h0);
    reset_n = 1'b1;
    send_bytes("Q\n", 2);
    check("midreset pulses", 128'(rdy_log.size() - r0), 128'd1);
    check("midreset ovf",    128'(ovf_cnt - o0), 128'd0);
    check("midreset len2",   128'(RXStringLen), 128'd1);
    check("midreset str2",   128'(RXString), 128'h51);

    // Back-to-back single-char strings at full baud.
    r0 = rdy_log.size();
    send_bytes("A\rB\r", 4);
    check("b2b pulses", 128'(rdy_log.size() - r0), 128'd2);
    if (rdy_log.size() >= r0 + 2) begin
      check("b2b first str",  128'(rdy_log[r0].str),   128'h41);
      check("b2b first len",  128'(rdy_log[r0].len),   128'd1);
      check("b2b first lat",  128'(rdy_log[r0].lat),   128'd1);
      check("b2b second str", 128'(rdy_log[r0+1].str), 128'h42);
      check("b2b second len", 128'(rdy_log[r0+1].len), 128'd1);
      check("b2b second lat", 128'(rdy_log[r0+1].lat), 128'd1);
    end else begin
      tests++;
      fails++;
      $display("FAIL b2b events: got %0d ready pulses expected 2", rdy_log.size() - r0);
    end

    check("ready and ovf together", 128'(both_cnt), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
